regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file. Successor to the 32x32, 2-read/1-write register file.
- Generalises width, depth and read-port count. Adds a second write port, optional write-to-read bypass, asynchronous reset clear and a per-register busy scoreboard for pipeline hazard detection.
- Sits in the CPU decode/writeback stage; the test port feeds the board display.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads show stored value only

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- raddr  in  NRD*ADDR_W  read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data; port i = bits [i*DATA_W +: DATA_W]
- rbusy  out  NRD  busy flag of each read address
- wen0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- wen1  in  1  write enable, port 1
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- set_en  in  1  mark a register busy (producer issued)
- set_addr  in  ADDR_W  register to mark busy
- test_addr  in  ADDR_W  debug read address
- test_data  out  DATA_W  debug read data (stored value, never bypassed)

Behaviour:
- Reset: resetn low asynchronously clears all registers and all busy bits to 0. Every output reads 0 while reset is held. Writes and sets are ignored during reset.
- Register 0 is hardwired: it always reads 0 and is never busy. Writes and sets to address 0 are discarded.
- Writes:
  - Synchronous on the rising edge of clk when wenX=1 and waddrX != 0.
  - Both ports may write different addresses in the same cycle.
  - If both write the same address, port 1 wins.
- Reads:
  - Combinational, zero latency. Priority per read port:
    1. addr = 0 -> 0
    2. BYPASS=1 and wen1 and waddr1 = addr -> wdata1
    3. BYPASS=1 and wen0 and waddr0 = addr -> wdata0
    4. otherwise the stored value
  - With BYPASS=0 the written value appears on the cycle after the edge.
- Scoreboard (one busy bit per register, updated at the rising edge of clk):
  - A write on either port to address A clears busy[A].
  - set_en with set_addr=A sets busy[A].
  - If a set and a write target the same A in the same cycle, set wins: busy stays 1, for the new producer. The data write still occurs.
  - rbusy[i] = busy[raddr_i], combinational.
  - With BYPASS=1, rbusy[i] is forced to 0 when a same-cycle write to that address is in flight.
- Widths: no arithmetic. Addresses are used unsigned and every value of 2**ADDR_W is legal; there is no out-of-range case.
- Reset deasserting mid-cycle: the first write takes effect on the first rising edge with resetn high.

Test Plan:
- Reset then read all: assert resetn=0 after registers hold data -> immediately all rdata=0, test_data=0, rbusy=0. Hold after release until the first write.
- Basic write/read: wen0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr port0=5, port1=5 -> both rdata=0xDEADBEEF; test_addr=5 -> 0xDEADBEEF.
- Dual-write collision: wen0=wen1=1, both to address 7, wdata0=0x11, wdata1=0x22 -> reg7=0x22. Distinct addresses 3/4 with 0xA/0xB -> both stored.
- Bypass: BYPASS=1, write 0x1234 to reg 9 while reading reg 9 in the same cycle -> rdata=0x1234 before the edge. BYPASS=0 -> the old value that cycle, 0x1234 the next.
- Register 0: write 0xFFFFFFFF to address 0 via both ports and set_en on address 0 -> rdata=0, rbusy=0, test_data=0.
- Scoreboard: set_en on 12 -> rbusy=1 next cycle. Write 12 -> rbusy=0 after the edge. Set and write 12 in the same cycle -> busy=1 and data updated.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file.
// master : decode/writeback logic (drives addresses, write and set requests)
// slave  : the register file (returns read data, busy flags, debug data)
// Signals:
//   raddr/rdata/rbusy      packed per read port, port i at [i*W +: W]
//   wen0/waddr0/wdata0     write port 0
//   wen1/waddr1/wdata1     write port 1 (wins on address collision)
//   set_en/set_addr        mark a register busy
//   test_addr/test_data    debug read of the stored value
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2
);
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  wen0;
    logic [ADDR_W-1:0]     waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  wen1;
    logic [ADDR_W-1:0]     waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic                  set_en;
    logic [ADDR_W-1:0]     set_addr;
    logic [ADDR_W-1:0]     test_addr;
    logic [DATA_W-1:0]     test_data;

    modport master (
        output raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
               set_en, set_addr, test_addr,
        input  rdata, rbusy, test_data
    );

    modport slave (
        input  raddr, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
               set_en, set_addr, test_addr,
        output rdata, rbusy, test_data
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with busy scoreboard.
// Two write ports (port 1 wins on collision), NRD combinational read ports
// with optional same-cycle write bypass, and a debug port that always shows
// the stored value. Register 0 reads as zero and is never busy.
// Ports:
//   clk    rising-edge clock
//   resetn asynchronous active-low clear of all registers and busy bits
//   bus    regfile_mp_if.slave, see the interface file for the signal list
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         resetn,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Port 1 is applied after port 0 so it wins a collision; the set is
    // applied last so a new producer keeps the register busy.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int r = 1; r < DEPTH; r++) begin
            if (bus.wen0 && (bus.waddr0 == ADDR_W'(r))) begin
                mem_d[r]  = bus.wdata0;
                busy_d[r] = 1'b0;
            end
            if (bus.wen1 && (bus.waddr1 == ADDR_W'(r))) begin
                mem_d[r]  = bus.wdata1;
                busy_d[r] = 1'b0;
            end
            if (bus.set_en && (bus.set_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit0;
        logic              hit1;

        assign addr = bus.raddr[g*ADDR_W +: ADDR_W];
        assign hit1 = (BYPASS != 0) && bus.wen1 && (bus.waddr1 == addr);
        assign hit0 = (BYPASS != 0) && bus.wen0 && (bus.waddr0 == addr);

        // Outputs are gated by resetn so bypassed write data cannot leak
        // out while reset is held.
        assign bus.rdata[g*DATA_W +: DATA_W] =
            (!resetn || (addr == '0)) ? '0 :
            hit1                      ? bus.wdata1 :
            hit0                      ? bus.wdata0 :
                                        mem_q[addr];

        // A write in flight retires the producer, so the consumer sees it
        // as ready together with the bypassed data.
        assign bus.rbusy[g] = resetn && !hit0 && !hit1 && busy_q[addr];
    end

    assign bus.test_data = resetn ? mem_q[bus.test_addr] : '0;
endmodule
